// File: rtl/alu_pkg.sv
// Shared ALU definitions. The CPU decoder also imports this package for the opcode map.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned MUL_OPW   = 16;

  // Opcode map. Any value not listed here is reserved.
  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_SUB = 6'h02;
  localparam logic [5:0] OP_AND = 6'h03;
  localparam logic [5:0] OP_OR  = 6'h04;
  localparam logic [5:0] OP_XOR = 6'h05;
  localparam logic [5:0] OP_NOT = 6'h06;
  localparam logic [5:0] OP_SLL = 6'h07;
  localparam logic [5:0] OP_SRL = 6'h08;
  localparam logic [5:0] OP_SRA = 6'h09;
  localparam logic [5:0] OP_MUL = 6'h16;

  // Condition flags produced alongside every result.
  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } alu_flags_t;

  // True when a 32-bit word is representable as a 16-bit signed value,
  // i.e. bits [31:15] are all copies of the same sign bit.
  function automatic logic fits_s16(input logic [ALU_WIDTH-1:0] x);
    return (x[ALU_WIDTH-1:MUL_OPW-1] == '0) || (x[ALU_WIDTH-1:MUL_OPW-1] == '1);
  endfunction

endpackage

// File: rtl/alu_mul16.sv
// Signed 16x16 multiply with operand range check. Purely combinational; the
// enclosing ALU registers the product together with the other results.
module alu_mul16
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  output logic [ALU_WIDTH-1:0] product,
  output logic                 v
);

  logic signed [ALU_WIDTH-1:0] a_ext;
  logic signed [ALU_WIDTH-1:0] b_ext;

  // Sign-extend the low halves and form the full 32-bit product; a 16x16
  // signed product always fits in 32 bits, so truncation loses nothing.
  always_comb begin
    a_ext   = {{(ALU_WIDTH-MUL_OPW){a[MUL_OPW-1]}}, a[MUL_OPW-1:0]};
    b_ext   = {{(ALU_WIDTH-MUL_OPW){b[MUL_OPW-1]}}, b[MUL_OPW-1:0]};
    product = a_ext * b_ext;
  end

  // Flag operands whose upper bits carry information the multiplier ignores.
  always_comb begin
    v = !(fits_s16(a) && fits_s16(b));
  end

endmodule

// File: rtl/alu.sv
// 32-bit execute-stage ALU: combinational datapath into one register stage
// holding the result and the N/Z/V flags.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic [WIDTH-1:0] alu_out,
  output logic             n,
  output logic             z,
  output logic             v
);

  logic [WIDTH-1:0] result_d, result_q;
  alu_flags_t       flags_d, flags_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] mul_product;
  logic             mul_v;

  alu_mul16 u_mul16 (
    .a       (alu_in1),
    .b       (alu_in2),
    .product (mul_product),
    .v       (mul_v)
  );

  // Arithmetic terms shared by the opcode select below.
  always_comb begin
    sum   = alu_in1 + alu_in2;
    diff  = alu_in1 - alu_in2;
    shamt = alu_in2[4:0];
  end

  // Opcode select: result and overflow, then N/Z derived from the result.
  always_comb begin
    result_d  = '0;
    flags_d   = '0;
    case (op)
      OP_ADD: begin
        result_d  = sum;
        flags_d.v = (alu_in1[WIDTH-1] == alu_in2[WIDTH-1]) &&
                    (sum[WIDTH-1] != alu_in1[WIDTH-1]);
      end
      OP_SUB: begin
        result_d  = diff;
        flags_d.v = (alu_in1[WIDTH-1] != alu_in2[WIDTH-1]) &&
                    (diff[WIDTH-1] != alu_in1[WIDTH-1]);
      end
      OP_AND: result_d = alu_in1 & alu_in2;
      OP_OR:  result_d = alu_in1 | alu_in2;
      OP_XOR: result_d = alu_in1 ^ alu_in2;
      OP_NOT: result_d = ~alu_in1;
      OP_SLL: result_d = alu_in1 << shamt;
      OP_SRL: result_d = alu_in1 >> shamt;
      OP_SRA: result_d = $signed(alu_in1) >>> shamt;
      OP_MUL: begin
        result_d  = mul_product;
        flags_d.v = mul_v;
      end
      default: begin
        result_d  = '0;
        flags_d.v = 1'b0;
      end
    endcase
    flags_d.n = result_d[WIDTH-1];
    flags_d.z = (result_d == '0);
  end

  // Single register stage; reset clears result and flags without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Registered outputs.
  always_comb begin
    alu_out = result_q;
    n       = flags_q.n;
    z       = flags_q.z;
    v       = flags_q.v;
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized traffic checked
// against an integer-arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [5:0]  op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_out;
  logic        n;
  logic        z;
  logic        v;

  int unsigned vectors;
  int unsigned miscompares;

  localparam longint S32_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint S32_MIN = -64'sh0000_0000_8000_0000;

  alu #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .alu_in1 (alu_in1),
    .alu_in2 (alu_in2),
    .alu_out (alu_out),
    .n       (n),
    .z       (z),
    .v       (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {result, n, z, v} using wide signed arithmetic.
  function automatic logic [34:0] model(input logic [5:0] mop, input logic [31:0] a,
                                        input logic [31:0] b);
    longint    sa;
    longint    sb;
    longint    r;
    logic [63:0] rbits;
    logic [31:0] res;
    logic      ov;
    int        sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    r  = 0;
    ov = 1'b0;
    case (mop)
      6'h01: begin r = sa + sb; ov = (r > S32_MAX) || (r < S32_MIN); end
      6'h02: begin r = sa - sb; ov = (r > S32_MAX) || (r < S32_MIN); end
      6'h03: r = longint'(a & b);
      6'h04: r = longint'(a | b);
      6'h05: r = longint'(a ^ b);
      6'h06: r = longint'(~a);
      6'h07: r = longint'(a) << sh;
      6'h08: r = longint'(a) >> sh;
      6'h09: r = sa >>> sh;
      6'h16: begin
        r  = longint'($signed(a[15:0])) * longint'($signed(b[15:0]));
        ov = (sa > 32767) || (sa < -32768) || (sb > 32767) || (sb < -32768);
      end
      default: r = 0;
    endcase
    rbits = r;
    res   = rbits[31:0];
    return {res, res[31], (res == 32'd0), ov};
  endfunction

  // Present one operation and sample the registered result just after the edge.
  task automatic apply(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    op      = o;
    alu_in1 = a;
    alu_in2 = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [10];
    int unsigned k;
    ops = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h16};
    k = $urandom_range(0, 11);
    if (k >= 10) return 6'($urandom_range(10, 63)); // mostly reserved region
    return ops[k];
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] x;
    x = $urandom;
    if ($urandom_range(0, 2) == 0) x = {{16{x[15]}}, x[15:0]};
    return x;
  endfunction

  task automatic test_reset();
    logic [34:0] got;
    rst = 1'b1;
    op = 6'h00; alu_in1 = '0; alu_in2 = '0;
    #3;
    got = {alu_out, n, z, v};
    vectors++;
    if (got !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_initial: got out=%08h nzv=%b, expected out=00000000 nzv=000", alu_out, {n, z, v});
    end
    @(negedge clk);
    rst = 1'b0;
    // Register a nonzero, negative, overflowing result, then reset between edges.
    apply(6'h01, 32'h7FFF_FFFF, 32'h0000_0001);
    got = {alu_out, n, z, v};
    vectors++;
    if (got !== {32'h8000_0000, 1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_preload: got out=%08h nzv=%b, expected out=80000000 nzv=101", alu_out, {n, z, v});
    end
    #1 rst = 1'b1;
    #1;
    got = {alu_out, n, z, v};
    vectors++;
    if (got !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_async: got out=%08h nzv=%b, expected out=00000000 nzv=000", alu_out, {n, z, v});
    end
    @(negedge clk);
    rst = 1'b0;
    apply(6'h16, 32'h0000_00A4, 32'h0000_0051);
    got = {alu_out, n, z, v};
    vectors++;
    if (got !== {32'd13284, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_resume: got out=%08h nzv=%b, expected out=%08h nzv=000", alu_out, {n, z, v}, 32'd13284);
    end
  endtask

  task automatic test_directed();
    logic [5:0]  t_op [12];
    logic [31:0] t_a  [12];
    logic [31:0] t_b  [12];
    logic [34:0] t_exp[12];
    logic [34:0] got;
    t_op = '{6'h16, 6'h16, 6'h16, 6'h16, 6'h16, 6'h02, 6'h02, 6'h01, 6'h09, 6'h08, 6'h3F, 6'h07};
    t_a  = '{32'h0000_00A4, 32'hFFFF_FFFF, 32'h0, 32'h0000_7FFF, 32'h0008_7FFF, 32'h8000_0000,
             32'd5, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'h0000_0001};
    t_b  = '{32'h0000_0051, 32'hFFFF_FFFF, 32'h1, 32'h0000_7FFF, 32'h000F_7FFF, 32'h7FFF_FFFF,
             32'd5, 32'h0000_0001, 32'd4, 32'd4, 32'h9ABC_DEF0, 32'h0000_003F};
    t_exp = '{{32'd13284, 3'b000}, {32'd1, 3'b000}, {32'd0, 3'b010}, {32'd1073676289, 3'b000},
              {32'h3FFF_0001, 3'b001}, {32'h0000_0001, 3'b001}, {32'd0, 3'b010},
              {32'h8000_0000, 3'b101}, {32'hF800_0000, 3'b100}, {32'h0800_0000, 3'b000},
              {32'd0, 3'b010}, {32'h8000_0000, 3'b100}};
    for (int i = 0; i < 12; i++) begin
      apply(t_op[i], t_a[i], t_b[i]);
      got = {alu_out, n, z, v};
      vectors++;
      if (got !== t_exp[i]) begin
        miscompares++;
        $display("FAIL directed_%0d op=%02h a=%08h b=%08h: got out=%08h nzv=%b, expected out=%08h nzv=%b",
                 i, t_op[i], t_a[i], t_b[i], alu_out, {n, z, v}, t_exp[i][34:3], t_exp[i][2:0]);
      end
    end
  endtask

  task automatic test_mul_sweep();
    logic [31:0] a;
    logic [31:0] exp_out;
    logic        exp_v;
    for (int unsigned av = 32700; av <= 42700; av += 10) begin
      a = av;
      apply(6'h16, a, 32'd32700);
      exp_v   = (av >= 32768);
      exp_out = model(6'h16, a, 32'd32700) >> 3;
      vectors++;
      if (v !== exp_v || (!exp_v && alu_out !== av * 32'd32700) || alu_out !== exp_out) begin
        miscompares++;
        $display("FAIL mul_sweep a=%0d: got out=%08h v=%b, expected out=%08h v=%b",
                 av, alu_out, v, exp_out, exp_v);
      end
    end
  endtask

  task automatic test_reserved();
    logic [5:0] o;
    for (int i = 0; i < 40; i++) begin
      o = 6'($urandom_range(10, 63));
      if (o == 6'h16) o = 6'h3F;
      apply(o, $urandom, $urandom);
      vectors++;
      if ({alu_out, n, z, v} !== {32'd0, 3'b010}) begin
        miscompares++;
        $display("FAIL reserved op=%02h: got out=%08h nzv=%b, expected out=00000000 nzv=010",
                 o, alu_out, {n, z, v});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] prev;
    logic [34:0] exp;
    logic [5:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    prev = {alu_out, n, z, v};
    for (int i = 0; i < 400; i++) begin
      o = rand_op();
      a = rand_operand();
      b = rand_operand();
      exp = model(o, a, b);
      op = o; alu_in1 = a; alu_in2 = b;
      #3;
      vectors++;
      if ({alu_out, n, z, v} !== prev) begin
        miscompares++;
        $display("FAIL b2b_hold_%0d: got out=%08h nzv=%b before edge, expected out=%08h nzv=%b",
                 i, alu_out, {n, z, v}, prev[34:3], prev[2:0]);
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({alu_out, n, z, v} !== exp) begin
        miscompares++;
        $display("FAIL b2b_%0d op=%02h a=%08h b=%08h: got out=%08h nzv=%b, expected out=%08h nzv=%b",
                 i, o, a, b, alu_out, {n, z, v}, exp[34:3], exp[2:0]);
      end
      prev = exp;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_mul_sweep();
    test_reserved();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
